// File: rtl/hack_pkg.sv
// Shared definitions for the multi-cycle Hack CPU: FSM states, instruction field
// positions and the jump-condition helper.
package hack_pkg;

   typedef enum logic [1:0] {
      EXEC    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2
   } stateT;

   localparam int I_TYPE  = 15;
   localparam int A_BIT   = 12;
   localparam int COMP_HI = 11;
   localparam int COMP_LO = 6;
   localparam int DEST_A  = 5;
   localparam int DEST_D  = 4;
   localparam int DEST_M  = 3;
   localparam int JUMP_HI = 2;
   localparam int JUMP_LO = 0;

   function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
      return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
   endfunction

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: zx/nx/zy/ny/f/no on comp[5:0], zero and negative flags.
// Zero latency, no flow control.
module hack_alu #(
   parameter int W = 16
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [5:0]   comp,
   output logic [W-1:0] res,
   output logic         zr,
   output logic         ng
);

   logic [W-1:0] xz, xn, yz, yn, fOut;

   always_comb begin
      xz   = comp[5] ? '0 : x;
      xn   = comp[4] ? ~xz : xz;
      yz   = comp[3] ? '0 : y;
      yn   = comp[2] ? ~yz : yz;
      fOut = comp[1] ? (xn + yn) : (xn & yn);
      res  = comp[0] ? ~fOut : fOut;
      zr   = (res == '0);
      ng   = res[W-1];
   end

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with a req/ack data-memory port; 1 cycle per non-memory
// instruction, 1+N per read or write, 1+Nrd+Nwr per read-modify-write; stalls on mem_ack.
module hack_cpu_mc
   import hack_pkg::*;
#(
   parameter int W      = 16,
   parameter int PC_W   = 15,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       inst,
   output logic [PC_W-1:0]   pc,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [W-1:0]      mem_wdata,
   input  logic [W-1:0]      mem_rdata,
   input  logic              mem_ack,
   output logic              retired,
   output logic              halted
);

   stateT           state, stateNext;
   logic [W-1:0]    aReg, dReg, resQ, yIn, aluOut, commitRes;
   logic [PC_W-1:0] pcReg;
   logic            zrQ, ngQ, aluZr, aluNg, commitZr, commitNg;
   logic            commit, issueRd, issueWr, latchRes, memDone, taken;
   logic            isC, aBit, destA, destD, destM;
   logic [5:0]      comp;
   logic [2:0]      jmp;

   assign isC   = inst[I_TYPE];
   assign aBit  = inst[A_BIT];
   assign comp  = inst[COMP_HI:COMP_LO];
   assign destA = inst[DEST_A];
   assign destD = inst[DEST_D];
   assign destM = inst[DEST_M];
   assign jmp   = inst[JUMP_HI:JUMP_LO];

   assign yIn = aBit ? mem_rdata : aReg;

   hack_alu #(.W(W)) uAlu (
      .x    (dReg),
      .y    (yIn),
      .comp (comp),
      .res  (aluOut),
      .zr   (aluZr),
      .ng   (aluNg)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= EXEC;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      commit    = 1'b0;
      issueRd   = 1'b0;
      issueWr   = 1'b0;
      latchRes  = 1'b0;
      memDone   = 1'b0;
      commitRes = aluOut;
      commitZr  = aluZr;
      commitNg  = aluNg;
      case (state)
         EXEC: begin
            if (!halted) begin
               if (!isC || (!aBit && !destM)) begin
                  commit = 1'b1;
               end else if (aBit) begin
                  issueRd   = 1'b1;
                  stateNext = RD_WAIT;
               end else begin
                  issueWr   = 1'b1;
                  latchRes  = 1'b1;
                  stateNext = WR_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (mem_ack) begin
               if (destM) begin
                  latchRes  = 1'b1;
                  stateNext = WR_WAIT;
               end else begin
                  commit    = 1'b1;
                  memDone   = 1'b1;
                  stateNext = EXEC;
               end
            end
         end
         WR_WAIT: begin
            if (mem_ack) begin
               commit    = 1'b1;
               memDone   = 1'b1;
               commitRes = resQ;
               commitZr  = zrQ;
               commitNg  = ngQ;
               stateNext = EXEC;
            end
         end
         default: stateNext = EXEC;
      endcase
      taken = commit & isC & jump_taken(jmp, commitZr, commitNg);
   end

   // Architectural state moves only on commit; the jump target is the pre-commit A.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aReg      <= '0;
         dReg      <= '0;
         pcReg     <= '0;
         resQ      <= '0;
         zrQ       <= 1'b0;
         ngQ       <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         halted    <= 1'b0;
      end else begin
         if (commit) begin
            if (!isC) begin
               aReg <= {{(W-15){1'b0}}, inst[14:0]};
            end else begin
               if (destA) aReg <= commitRes;
               if (destD) dReg <= commitRes;
            end
            if (taken) begin
               pcReg <= aReg[PC_W-1:0];
               if (aReg[PC_W-1:0] == pcReg) halted <= 1'b1;
            end else begin
               pcReg <= pcReg + PC_W'(1);
            end
         end
         if (issueRd || issueWr) begin
            mem_req  <= 1'b1;
            mem_we   <= issueWr;
            mem_addr <= aReg[ADDR_W-1:0];
         end
         if (latchRes) begin
            resQ      <= aluOut;
            zrQ       <= aluZr;
            ngQ       <= aluNg;
            mem_wdata <= aluOut;
            mem_we    <= 1'b1;
            mem_req   <= 1'b1;
         end
         if (memDone) mem_req <= 1'b0;
      end
   end

   assign pc      = pcReg;
   assign retired = commit & ~reset;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed and randomized bench for hack_cpu_mc; an instruction-level model
// predicts memory traffic, per-cycle handshake, retire timing, pc and halt.
module tb_hack_cpu_mc;

   logic        clk, reset;
   logic [15:0] inst;
   logic [14:0] pc;
   logic        mem_req, mem_we;
   logic [14:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        mem_ack, retired, halted;

   int checks = 0;
   int errors = 0;

   logic [15:0] mA, mD;
   logic [14:0] mPc;
   bit          mHalted;
   logic [15:0] memModel [int];

   logic [5:0] compCodes [0:17] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                                    6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                                    6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                                    6'b000111, 6'b000000, 6'b010101};

   hack_cpu_mc dut (
      .clk       (clk),
      .reset     (reset),
      .inst      (inst),
      .pc        (pc),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .retired   (retired),
      .halted    (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] memRead(input logic [14:0] a);
      if (memModel.exists(int'(a))) return memModel[int'(a)];
      return 16'h0000;
   endfunction

   // Hack mnemonic table in plain arithmetic: x = D, y = A or M.
   function automatic logic [15:0] compRef(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
      case (c)
         6'b101010: return 16'h0000;
         6'b111111: return 16'h0001;
         6'b111010: return 16'hFFFF;
         6'b001100: return x;
         6'b110000: return y;
         6'b001101: return ~x;
         6'b110001: return ~y;
         6'b001111: return 16'h0000 - x;
         6'b110011: return 16'h0000 - y;
         6'b011111: return x + 16'h0001;
         6'b110111: return y + 16'h0001;
         6'b001110: return x - 16'h0001;
         6'b110010: return y - 16'h0001;
         6'b000010: return x + y;
         6'b010011: return x - y;
         6'b000111: return y - x;
         6'b000000: return x & y;
         6'b010101: return x | y;
         default:   return 16'h0000;
      endcase
   endfunction

   function automatic bit jumpRef(input logic [2:0] j, input logic [15:0] v);
      bit lt, eq, gt;
      lt = $signed(v) < 0;
      eq = (v == 16'h0000);
      gt = !lt && !eq;
      return (j[2] && lt) || (j[1] && eq) || (j[0] && gt);
   endfunction

   function automatic logic [15:0] cInst(input logic a, input logic [5:0] c, input logic [2:0] d, input logic [2:0] j);
      return {3'b111, a, c, d, j};
   endfunction

   // Runs one instruction from a negedge; nRd/nWr are ack latencies in cycles.
   task automatic runInst(input logic [15:0] ins, input int nRd, input int nWr, input bit stray);
      bit          isC, aB, d3, tk;
      logic [14:0] addr, newPc;
      logic [15:0] rdVal, y, res, newA, newD;
      int          rdEnd, total;
      isC   = ins[15];
      aB    = isC && ins[12];
      d3    = isC && ins[3];
      addr  = mA[14:0];
      rdVal = memRead(addr);
      res   = 16'h0000;
      tk    = 1'b0;
      if (!isC) begin
         newA  = {1'b0, ins[14:0]};
         newD  = mD;
         newPc = mPc + 15'd1;
      end else begin
         y     = aB ? rdVal : mA;
         res   = compRef(ins[11:6], mD, y);
         tk    = jumpRef(ins[2:0], res);
         newA  = ins[5] ? res : mA;
         newD  = ins[4] ? res : mD;
         newPc = tk ? mA[14:0] : mPc + 15'd1;
      end
      rdEnd = 1 + (aB ? nRd : 0);
      total = rdEnd + (d3 ? nWr : 0);
      inst  = ins;
      for (int c = 1; c <= total; c++) begin
         mem_ack   = (stray && c == 1) || (aB && c == rdEnd) || (d3 && c == total);
         mem_rdata = (aB && c == rdEnd) ? rdVal : 16'($urandom);
         #1;
         chk("pc_hold", 32'(pc), 32'(mPc));
         chk("halted_low", 32'(halted), 32'(0));
         chk("mem_req", 32'(mem_req), 32'(c > 1));
         if (c > 1) begin
            chk("mem_we", 32'(mem_we), 32'(c > rdEnd));
            chk("mem_addr", 32'(mem_addr), 32'(addr));
            if (c > rdEnd) chk("mem_wdata", 32'(mem_wdata), 32'(res));
         end
         chk("retired", 32'(retired), 32'(c == total));
         @(negedge clk);
      end
      mem_ack = 1'b0;
      if (d3) memModel[int'(addr)] = res;
      if (tk && newPc == mPc) mHalted = 1'b1;
      mA  = newA;
      mD  = newD;
      mPc = newPc;
   endtask

   task automatic idleHalted(input int n);
      inst = 16'hFC10;
      for (int c = 0; c < n; c++) begin
         mem_ack = 1'b0;
         #1;
         chk("halt_flag", 32'(halted), 32'(1));
         chk("halt_pc", 32'(pc), 32'(mPc));
         chk("halt_req", 32'(mem_req), 32'(0));
         chk("halt_retired", 32'(retired), 32'(0));
         @(negedge clk);
      end
   endtask

   task automatic doReset();
      reset   = 1'b1;
      mem_ack = 1'b0;
      #1;
      chk("rst_req", 32'(mem_req), 32'(0));
      chk("rst_halted", 32'(halted), 32'(0));
      chk("rst_pc", 32'(pc), 32'(0));
      @(negedge clk);
      reset   = 1'b0;
      mA      = 16'h0000;
      mD      = 16'h0000;
      mPc     = 15'd0;
      mHalted = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      inst      = 16'h0000;
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      mA = 16'h0000; mD = 16'h0000; mPc = 15'd0; mHalted = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset_pc", 32'(pc), 32'(0));
      chk("reset_req", 32'(mem_req), 32'(0));
      chk("reset_we", 32'(mem_we), 32'(0));
      chk("reset_addr", 32'(mem_addr), 32'(0));
      chk("reset_wdata", 32'(mem_wdata), 32'(0));
      chk("reset_retired", 32'(retired), 32'(0));
      chk("reset_halted", 32'(halted), 32'(0));
      @(negedge clk);
      reset = 1'b0;

      // A-instruction, then M=D exposes A as the address and D as the data.
      runInst(16'h1234, 1, 1, 1'b0);
      runInst(16'hE308, 1, 2, 1'b0);

      // D=M+1 with a 3-cycle read.
      memModel[5] = 16'h0041;
      runInst(16'h0005, 1, 1, 1'b0);
      runInst(16'hFDD0, 3, 1, 1'b0);
      runInst(16'hE308, 1, 1, 1'b0);

      // M=M+1 read-modify-write.
      memModel[7] = 16'h0009;
      runInst(16'h0007, 1, 1, 1'b0);
      runInst(16'hFDC8, 2, 2, 1'b0);
      runInst(16'hFC10, 1, 1, 1'b0);

      // AM=D writes to the old A, then A takes D.
      runInst(16'h0003, 1, 1, 1'b0);
      runInst(cInst(1'b0, 6'b110000, 3'b010, 3'b000), 1, 1, 1'b0);
      runInst(16'h0020, 1, 1, 1'b0);
      runInst(16'hE328, 1, 2, 1'b0);
      runInst(16'hE308, 1, 1, 1'b0);

      // Jumps, then a self-jump that halts.
      runInst(cInst(1'b0, 6'b111010, 3'b010, 3'b000), 1, 1, 1'b0);
      runInst(16'h0010, 1, 1, 1'b0);
      runInst(16'hE304, 1, 1, 1'b0);
      chk("jlt_pc", 32'(pc), 32'(16'h0010));
      runInst(16'hE301, 1, 1, 1'b0);
      chk("jgt_pc", 32'(pc), 32'(16'h0011));
      runInst({1'b0, mPc + 15'd1}, 1, 1, 1'b0);
      runInst(16'hEA87, 1, 1, 1'b0);
      idleHalted(10);
      doReset();

      // Reset during a read wait; the stray ack afterwards must be ignored.
      runInst(16'h0009, 1, 1, 1'b0);
      inst    = 16'hFC10;
      mem_ack = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_req", 32'(mem_req), 32'(1));
      chk("mid_addr", 32'(mem_addr), 32'(9));
      reset = 1'b1;
      #1;
      chk("mid_req_async", 32'(mem_req), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      mA = 16'h0000; mD = 16'h0000; mPc = 15'd0; mHalted = 1'b0;
      runInst(16'hFC10, 2, 1, 1'b1);
      runInst(16'hE308, 1, 1, 1'b0);

      for (int i = 0; i < 250; i++) begin
         logic [15:0] ins;
         if ($urandom_range(0, 9) < 4)
            ins = {10'b0, 6'($urandom_range(0, 63))};
         else
            ins = cInst(1'($urandom_range(0, 1)), compCodes[$urandom_range(0, 17)],
                        3'($urandom_range(0, 7)),
                        ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
         runInst(ins, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), $urandom_range(0, 3) == 0);
         if (mHalted) begin
            idleHalted(3);
            doReset();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
